// File: rtl/spi_slave_frame.sv
// SPI mode-0 frame responder: address/command byte then up to NBYTES data bytes.
// Write frames land on BUS_OUT, read frames shift TX_BUS out on MISO.
//
// Ports:
//   Mclk, nReset              system clock, async active-low reset
//   SPI_clk, SPI_CS, SPI_MOSI SPI inputs (oversampled in Mclk domain)
//   SPI_MISO, SPI_MISO_OE     SPI output and its enable
//   TX_BUS                    frame returned on read, byte0 in MSBs
//   BUS_OUT, Rx_Len           last write frame and its complete byte count
//   Rx_Valid                  1-cycle pulse when BUS_OUT/Rx_Len update
//   Rx_Ovf                    set when a write frame exceeds NBYTES bytes
//   Rd_Done                   1-cycle pulse at the end of a read
//   Busy                      high from CS fall until back in IDLE
//   Rx_Err                    (SPI_SLV_CHECKSUM_EN only) bad/missing checksum
//
// Optional feature macro: SPI_SLV_CHECKSUM_EN (XOR checksum byte on writes
// and reads). Default build has no checksum.

module spi_slave_frame #(
    parameter logic [6:0] DEV_ADDR    = 7'h5A,
    parameter int         NBYTES      = 15,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          Mclk,
    input  logic                          nReset,
    input  logic                          SPI_clk,
    input  logic                          SPI_CS,
    input  logic                          SPI_MOSI,
    output logic                          SPI_MISO,
    output logic                          SPI_MISO_OE,
    input  logic [8*NBYTES-1:0]           TX_BUS,
    output logic [8*NBYTES-1:0]           BUS_OUT,
    output logic [$clog2(NBYTES+1)-1:0]   Rx_Len,
`ifdef SPI_SLV_CHECKSUM_EN
    output logic                          Rx_Err,
`endif
    output logic                          Rx_Valid,
    output logic                          Rx_Ovf,
    output logic                          Rd_Done,
    output logic                          Busy
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = 8 * NBYTES;
`ifdef SPI_SLV_CHECKSUM_EN
    localparam int TXW = BW + 8;
`else
    localparam int TXW = BW;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_IGNORE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Synchroniser: {sck, cs, mosi} per stage. CS resets to 0 so that a
    // frame already in progress at reset release never shows a CS fall.
    logic [2:0] r_sync [SYNC_STAGES];
    logic [1:0] r_prev;
    logic [2:0] w_cur;

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= {SPI_clk, SPI_CS, SPI_MOSI};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_cur[2:1];
        end
    end

    logic w_mosi;
    logic w_rise;
    logic w_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_active;
    logic w_end;
    logic w_start;
    logic w_last;
    logic w_match;
    logic [7:0] w_byte;
    logic [TXW-1:0] w_tx_load;

    logic [6:0]     r_shift;
    logic [2:0]     r_bit_cnt;
    logic [CW-1:0]  r_byte_cnt;
    logic [BW-1:0]  r_rx_buf;
    logic [TXW-1:0] r_tx;
    logic           r_miso;
    logic           r_oe;
    logic [BW-1:0]  r_bus;
    logic [CW-1:0]  r_len;
    logic           r_valid;
    logic           r_ovf;
    logic           r_rd_done;
    logic           r_busy;
    logic           r_cs_pend;
`ifdef SPI_SLV_CHECKSUM_EN
    logic [7:0]     r_xor;
    logic [7:0]     r_ck;
    logic           r_ck_got;
    logic           r_err;
    logic [7:0]     w_tx_ck;
`endif

    assign w_cur     = r_sync[SYNC_STAGES-1];
    assign w_mosi    = w_cur[0];
    // SCK edges only count while CS is low
    assign w_rise    = w_cur[2] & ~r_prev[1] & ~w_cur[1];
    assign w_fall    = ~w_cur[2] & r_prev[1] & ~w_cur[1];
    assign w_cs_fall = ~w_cur[1] & r_prev[0];
    assign w_cs_rise = w_cur[1] & ~r_prev[0];
    assign w_active  = (r_state == S_ADDR) || (r_state == S_WRITE) ||
                       (r_state == S_READ) || (r_state == S_IGNORE);
    assign w_end     = w_active & w_cs_rise;
    // A CS fall seen during DONE is replayed from r_cs_pend
    assign w_start   = (r_state == S_IDLE) & (w_cs_fall | r_cs_pend);
    assign w_last    = w_rise & (r_bit_cnt == 3'd7);
    assign w_byte    = {r_shift, w_mosi};
    assign w_match   = (r_shift == DEV_ADDR);

`ifdef SPI_SLV_CHECKSUM_EN
    always_comb begin
        w_tx_ck = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_tx_ck = w_tx_ck ^ TX_BUS[8*i +: 8];
        end
    end
    assign w_tx_load = {TX_BUS, w_tx_ck};
`else
    assign w_tx_load = TX_BUS;
`endif

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_end) begin
                    w_next = S_DONE;
                end else if (w_last) begin
                    if (!w_match)    w_next = S_IGNORE;
                    else if (w_mosi) w_next = S_READ;
                    else             w_next = S_WRITE;
                end
            end
            S_WRITE, S_READ, S_IGNORE: begin
                if (w_end) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_rx_buf   <= '0;
            r_tx       <= '0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_bus      <= '0;
            r_len      <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd_done  <= 1'b0;
            r_busy     <= 1'b0;
            r_cs_pend  <= 1'b0;
`ifdef SPI_SLV_CHECKSUM_EN
            r_xor      <= '0;
            r_ck       <= '0;
            r_ck_got   <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_rd_done <= 1'b0;
`ifdef SPI_SLV_CHECKSUM_EN
            r_err     <= 1'b0;
`endif
            if (r_state == S_DONE && w_cs_fall) begin
                r_cs_pend <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_cs_pend <= 1'b0;
            end

            if (w_start) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_ovf      <= 1'b0;
                r_busy     <= 1'b1;
                r_rx_buf   <= '0;
                r_miso     <= 1'b0;
                r_oe       <= 1'b0;
`ifdef SPI_SLV_CHECKSUM_EN
                r_xor      <= '0;
                r_ck_got   <= 1'b0;
`endif
            end

            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end

            if ((r_state == S_ADDR || r_state == S_WRITE) && w_rise) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (r_state == S_ADDR && w_last && w_match && w_mosi) begin
                r_tx <= w_tx_load;
                r_oe <= 1'b1;
            end

            if (r_state == S_WRITE && w_last) begin
                if (r_byte_cnt != CW'(NBYTES)) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_byte_cnt == CW'(i)) begin
                            r_rx_buf[BW-1-8*i -: 8] <= w_byte;
                        end
                    end
                    r_byte_cnt <= r_byte_cnt + CW'(1);
`ifdef SPI_SLV_CHECKSUM_EN
                    r_xor <= r_xor ^ w_byte;
                end else if (!r_ck_got) begin
                    r_ck     <= w_byte;
                    r_ck_got <= 1'b1;
`endif
                end else begin
                    r_ovf <= 1'b1;
                end
            end

            // Zero shifts in behind the frame, so MISO idles low afterwards
            if (r_state == S_READ && w_fall) begin
                r_miso <= r_tx[TXW-1];
                r_tx   <= {r_tx[TXW-2:0], 1'b0};
            end

            if (w_end) begin
`ifdef SPI_SLV_CHECKSUM_EN
                if (r_state == S_WRITE) begin
                    if (r_byte_cnt == CW'(NBYTES) && r_ck_got &&
                        r_ck == r_xor) begin
                        r_bus   <= r_rx_buf;
                        r_len   <= r_byte_cnt;
                        r_valid <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
`else
                if (r_state == S_WRITE && r_byte_cnt != '0) begin
                    r_bus   <= r_rx_buf;
                    r_len   <= r_byte_cnt;
                    r_valid <= 1'b1;
                end
`endif
                if (r_state == S_READ) begin
                    r_rd_done <= 1'b1;
                    r_oe      <= 1'b0;
                    r_miso    <= 1'b0;
                end
            end
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_OE = r_oe;
    assign BUS_OUT     = r_bus;
    assign Rx_Len      = r_len;
    assign Rx_Valid    = r_valid;
    assign Rx_Ovf      = r_ovf;
    assign Rd_Done     = r_rd_done;
    assign Busy        = r_busy;
`ifdef SPI_SLV_CHECKSUM_EN
    assign Rx_Err      = r_err;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame (default build): directed and random frames
// checked against a frame-level reference model.

module tb_spi_slave_frame;

    logic         Mclk = 1'b0;
    logic         nReset = 1'b0;
    logic         SPI_clk = 1'b0;
    logic         SPI_CS = 1'b1;
    logic         SPI_MOSI = 1'b0;
    logic         SPI_MISO;
    logic         SPI_MISO_OE;
    logic [119:0] TX_BUS = '0;
    logic [119:0] BUS_OUT;
    logic [3:0]   Rx_Len;
    logic         Rx_Valid;
    logic         Rx_Ovf;
    logic         Rd_Done;
    logic         Busy;

    always #5 Mclk = ~Mclk;

    spi_slave_frame dut (
        .Mclk        (Mclk),
        .nReset      (nReset),
        .SPI_clk     (SPI_clk),
        .SPI_CS      (SPI_CS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .TX_BUS      (TX_BUS),
        .BUS_OUT     (BUS_OUT),
        .Rx_Len      (Rx_Len),
        .Rx_Valid    (Rx_Valid),
        .Rx_Ovf      (Rx_Ovf),
        .Rd_Done     (Rd_Done),
        .Busy        (Busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int valid_cnt;
    int done_cnt;

    always @(negedge Mclk) begin
        if (Rx_Valid) valid_cnt++;
        if (Rd_Done) done_cnt++;
    end

    logic [7:0]   fr [20];
    int           fr_len;
    int           fr_bits;
    int           rst_bit;
    logic         cap [160];
    logic         oe_seen;
    logic         busy_mid;
    logic [119:0] tx_lat;
    logic [119:0] m_bus = '0;
    int           m_len = 0;

    function automatic logic [119:0] r120();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[119:0];
    endfunction

    task automatic load_frame(input logic [159:0] v, input int nbytes,
                              input int nbits);
        for (int i = 0; i < 20; i++) begin
            fr[i] = (i < 20) ? v[159-8*i -: 8] : 8'h00;
        end
        fr_len = nbytes;
        fr_bits = nbits;
    endtask

    // Master side: SCK period 160 ns, MOSI set after each fall,
    // MISO captured at each rise.
    task automatic run_frame();
        int total;
        valid_cnt = 0;
        done_cnt = 0;
        oe_seen = 1'b0;
        busy_mid = 1'b0;
        tx_lat = TX_BUS;
        total = fr_len * 8 + fr_bits;
        SPI_CS = 1'b0;
        #160;
        for (int b = 0; b < total; b++) begin
            SPI_MOSI = fr[b/8][7-(b%8)];
            if (b == rst_bit) begin
                nReset = 1'b0;
                #30;
                nReset = 1'b1;
                #50;
            end else begin
                #80;
            end
            SPI_clk = 1'b1;
            cap[b] = SPI_MISO;
            if (b >= 8) oe_seen = oe_seen | SPI_MISO_OE;
            if (b == 8) busy_mid = Busy;
            if (b == 12) TX_BUS = r120();
            #80;
            SPI_clk = 1'b0;
        end
        #160;
        SPI_CS = 1'b1;
        #400;
    endtask

    task automatic check_frame(input string tag);
        int total;
        int nfull;
        int n;
        int nb;
        logic [6:0] addr;
        logic rw;
        logic rst;
        logic e_valid;
        logic e_done;
        logic e_ovf;
        logic e_oe;
        logic [119:0] g;
        logic [119:0] e;
        logic extra;
        total = fr_len * 8 + fr_bits;
        nfull = fr_len - 1;
        addr = fr[0][7:1];
        rw = fr[0][0];
        rst = (rst_bit >= 0) && (rst_bit < total);
        e_valid = 1'b0;
        e_done = 1'b0;
        e_ovf = 1'b0;
        e_oe = 1'b0;
        if (rst) begin
            m_bus = '0;
            m_len = 0;
        end else if (addr == 7'h5A && !rw) begin
            n = (nfull > 15) ? 15 : nfull;
            if (n > 0) begin
                m_bus = '0;
                for (int k = 0; k < n; k++) begin
                    m_bus[119-8*k -: 8] = fr[k+1];
                end
                m_len = n;
                e_valid = 1'b1;
            end
            e_ovf = (nfull > 15);
        end else if (addr == 7'h5A) begin
            e_done = 1'b1;
            e_oe = (total > 8);
        end
        chk({tag, "_valid"}, valid_cnt, e_valid);
        chk({tag, "_rddone"}, done_cnt, e_done);
        chk({tag, "_bus"}, BUS_OUT, m_bus);
        chk({tag, "_len"}, Rx_Len, m_len);
        chk({tag, "_ovf"}, Rx_Ovf, e_ovf);
        chk({tag, "_busy_end"}, Busy, 0);
        chk({tag, "_oe_end"}, SPI_MISO_OE, 0);
        chk({tag, "_miso_end"}, SPI_MISO, 0);
        if (!rst) chk({tag, "_oe_seen"}, oe_seen, e_oe);
        if (!rst && total > 8) chk({tag, "_busy_mid"}, busy_mid, 1);
        if (e_done) begin
            nb = total - 8;
            g = '0;
            e = '0;
            extra = 1'b0;
            for (int k = 0; k < nb; k++) begin
                if (k < 120) begin
                    g[119-k] = cap[k+8];
                    e[119-k] = tx_lat[119-k];
                end else begin
                    extra = extra | cap[k+8];
                end
            end
            chk({tag, "_rd_data"}, g, e);
            chk({tag, "_rd_tail"}, extra, 0);
        end
    endtask

    initial begin
        rst_bit = -1;
        #20;
        chk("rst_bus", BUS_OUT, 0);
        chk("rst_len", Rx_Len, 0);
        chk("rst_valid", Rx_Valid, 0);
        chk("rst_ovf", Rx_Ovf, 0);
        chk("rst_rddone", Rd_Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_miso", SPI_MISO, 0);
        chk("rst_oe", SPI_MISO_OE, 0);
        nReset = 1'b1;
        #200;
        chk("idle_busy", Busy, 0);

        load_frame({128'hB43FA0BCFADFE3410021BBC9FAE25A1F, 32'h0}, 16, 0);
        run_frame();
        check_frame("tp_write");
        chk("tp_write_lit", BUS_OUT, 120'h3FA0BCFADFE3410021BBC9FAE25A1F);

        TX_BUS = 120'h2F900921F4A254E4FF0012DCBBAA45;
        load_frame({8'hB5, 152'h0}, 16, 0);
        run_frame();
        check_frame("tp_read");

        TX_BUS = r120();
        load_frame({128'h6611223344556677889900AABBCCDDEE, 32'h0}, 16, 0);
        run_frame();
        check_frame("tp_ignore");
        chk("tp_ignore_lit", BUS_OUT, 120'h3FA0BCFADFE3410021BBC9FAE25A1F);

        load_frame({40'hB411223350, 120'h0}, 4, 4);
        run_frame();
        check_frame("tp_short");
        chk("tp_short_lit", BUS_OUT, 120'h112233000000000000000000000000);

        load_frame({8'hB4, 136'h0102030405060708090A0B0C0D0E0F1011, 16'h0},
                   18, 0);
        run_frame();
        check_frame("tp_ovf");

        rst_bit = 5 * 8 + 3;
        load_frame({128'hB4A1A2A3A4A5A6A7A8A9AAABACADAEAF, 32'h0}, 16, 0);
        run_frame();
        check_frame("tp_reset");
        rst_bit = -1;

        load_frame({128'hB4C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 32'h0}, 16, 0);
        run_frame();
        check_frame("tp_after_rst");

        for (int f = 0; f < 12; f++) begin
            TX_BUS = r120();
            for (int i = 0; i < 20; i++) fr[i] = 8'($urandom());
            if ($urandom_range(0, 2) != 0) begin
                fr[0] = {7'h5A, 1'($urandom())};
            end
            fr_len = $urandom_range(1, 18);
            fr_bits = $urandom_range(0, 7);
            run_frame();
            check_frame($sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
